// File: rtl/pipeline_ifr_queue.sv
// Instruction-fetch-result queue between IFP and ID.
// Captures {PC, instruction} from the selected fetch channel once that
// channel has data. Presents the oldest entry to ID from registered state
// only. Holds IFP via ifp_hold while the data is not ready or the queue is full.
module pipeline_ifr_queue #(
  parameter int              XLEN        = 64,
  parameter int              ILEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              NCH         = 2,
  parameter logic [ILEN-1:0] BUBBLE_INST = 32'h00000013,
  localparam int             CSW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [XLEN-1:0]     pc_IFP,
  input  logic                pc_valid,
  input  logic [CSW-1:0]      ch_sel,
  input  logic [NCH*ILEN-1:0] ch_dout,
  input  logic [NCH-1:0]      ch_ready,
  output logic [XLEN-1:0]     pc_IFR,
  output logic [ILEN-1:0]     Instruction,
  output logic                inst_valid,
  output logic                ifp_hold,
  output logic [31:0]         wait_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            sel_ok;
  logic [ILEN-1:0] sel_data;
  logic            push;
  logic            pop;
  logic            full;

  // Pick the ready flag and data of the addressed channel; an index with no
  // matching channel leaves sel_ok low, so it reads as "not ready".
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred on the no-match path.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel == CSW'(k)) begin
        sel_ok   = ch_ready[k];
        sel_data = ch_dout[k*ILEN +: ILEN];
      end
    end
  end

  assign inst_valid = (count != '0);
  assign full       = (count == FULL_COUNT);
  assign pop        = inst_valid && !stall;
  assign push       = pc_valid && sel_ok && (!full || pop) && !flush;
  assign ifp_hold   = pc_valid && !push && !flush;

  // The head is driven from stored state only. An empty queue shows a bubble.
  assign pc_IFR      = inst_valid ? pc_mem[rd_ptr]   : '0;
  assign Instruction = inst_valid ? inst_mem[rd_ptr] : BUBBLE_INST;

  // Pointer and occupancy bookkeeping. Flush wins over push, pop and stall.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the tail on each accepted fetch.
  // NOTE: the storage array is deliberately not reset. Its contents are
  // masked by count, so clearing it would add reset fan-out for no
  // observable effect.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc_IFP;
      inst_mem[wr_ptr] <= sel_data;
    end
  end

  // Saturating count of cycles a presented fetch waited on its channel. A
  // flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cycles <= '0;
    end else if (pc_valid && !sel_ok && !flush && (wait_cycles != '1)) begin
      wait_cycles <= wait_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ifr_queue.sv
// Self-checking bench for pipeline_ifr_queue.
// It uses a queue-based reference model with directed scenarios and a
// randomized run.
module tb_pipeline_ifr_queue;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam logic [31:0] BUBBLE = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            flush;
  logic [63:0]     pc_IFP;
  logic            pc_valid;
  logic [0:0]      ch_sel;
  logic [63:0]     ch_dout;
  logic [1:0]      ch_ready;
  logic [63:0]     pc_IFR;
  logic [31:0]     Instruction;
  logic            inst_valid;
  logic            ifp_hold;
  logic [31:0]     wait_cycles;

  pipeline_ifr_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NCH(NCH), .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_IFP(pc_IFP), .pc_valid(pc_valid), .ch_sel(ch_sel),
    .ch_dout(ch_dout), .ch_ready(ch_ready),
    .pc_IFR(pc_IFR), .Instruction(Instruction), .inst_valid(inst_valid),
    .ifp_hold(ifp_hold), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of fetched entries plus a wait counter.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  entry_t      m_new;
  logic [31:0] m_wait;
  logic        m_push, m_pop, m_ready, m_flush, m_pv;
  logic        exp_hold;

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [63:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : 64'd0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return (mq.size() != 0) ? mq[0].inst : BUBBLE;
  endfunction

  // Apply one cycle of inputs and predict this cycle's decisions.
  task automatic drive(input logic st, input logic fl, input logic pv,
                       input logic [63:0] pc, input int sel,
                       input logic [31:0] rom_d, input logic [31:0] dram_d,
                       input logic [1:0] rdy);
    stall    = st;
    flush    = fl;
    pc_valid = pv;
    pc_IFP   = pc;
    ch_sel   = 1'(sel);
    ch_dout  = {dram_d, rom_d};
    ch_ready = rdy;
    m_ready  = (sel < NCH) && rdy[sel];
    m_pop    = (mq.size() != 0) && !st;
    m_push   = pv && m_ready && !fl && ((mq.size() < DEPTH) || m_pop);
    exp_hold = pv && !m_push && !fl;
    m_flush  = fl;
    m_pv     = pv;
    m_new.pc   = pc;
    m_new.inst = (sel == 0) ? rom_d : dram_d;
    #1;
  endtask

  // Advance one clock edge and update the model, then return at the negedge.
  task automatic tick();
    @(posedge clk);
    if (m_flush) begin
      mq.delete();
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_new);
    end
    if (m_pv && !m_ready && !m_flush && (m_wait != 32'hFFFFFFFF)) m_wait++;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 0, 32'd0, 32'd0, 2'b01);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0 || pc_IFR !== 64'd0 || Instruction !== BUBBLE || wait_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b pc=%h inst=%h wait=%0d want v=0 pc=0 inst=%h wait=0",
               inst_valid, pc_IFR, Instruction, wait_cycles, BUBBLE);
    end
    reset = 1'b1;
    mq.delete();
    m_wait = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_rom_stream();
    for (int i = 0; i < 6; i++) begin
      logic [63:0] pc;
      pc = 64'h1000 + 64'(4 * i);
      drive(1'b0, 1'b0, (i < 3), pc, 0, {16'hA000, pc[15:0]}, 32'hDEAD0000, 2'b01);
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL rom_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()) begin
        n_fail++;
        $display("FAIL rom_out[%0d]: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                 i, inst_valid, pc_IFR, Instruction, exp_valid(), exp_pc(), exp_inst());
      end
    end
  endtask

  task automatic test_dram_wait();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, (i < 4), 64'h2000, 1, 32'h11111111, 32'h00500093,
            (i < 3) ? 2'b01 : 2'b11);
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL dram_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()
          || wait_cycles !== m_wait) begin
        n_fail++;
        $display("FAIL dram_out[%0d]: got v=%b inst=%h wait=%0d want v=%b inst=%h wait=%0d",
                 i, inst_valid, Instruction, wait_cycles, exp_valid(), exp_inst(), m_wait);
      end
    end
  endtask

  task automatic test_fill();
    // Five fetches under stall, one pop+push on release, one more under stall, then drain.
    for (int i = 0; i < 12; i++) begin
      logic st, pv;
      logic [63:0] pc;
      st = (i < 5) || (i == 6);
      pv = (i < 7);
      pc = 64'h3000 + 64'(4 * i);
      drive(st, 1'b0, pv, pc, 0, 32'hB0000000 | 32'(i), 32'd0, 2'b01);
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL fill_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()) begin
        n_fail++;
        $display("FAIL fill_out[%0d]: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                 i, inst_valid, pc_IFR, Instruction, exp_valid(), exp_pc(), exp_inst());
      end
    end
  endtask

  task automatic test_flush();
    // Fill under stall, then flush with stall and an incoming fetch, then idle.
    for (int i = 0; i < 7; i++) begin
      drive(i != 6, (i == 5), (i < 6), 64'h4000 + 64'(4 * i), 0, 32'hC0000000 | 32'(i),
            32'd0, 2'b01);
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL flush_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()) begin
        n_fail++;
        $display("FAIL flush_out[%0d]: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                 i, inst_valid, pc_IFR, Instruction, exp_valid(), exp_pc(), exp_inst());
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 1'b0, (i < 11), 64'h5000 + 64'(4 * i), 0, 32'hD0000000 | 32'(i),
            32'd0, 2'b01);
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL wrap_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()) begin
        n_fail++;
        $display("FAIL wrap_out[%0d]: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                 i, inst_valid, pc_IFR, Instruction, exp_valid(), exp_pc(), exp_inst());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 64'h6000 + 64'(4 * i), 0, 32'hE0000000 | 32'(i), 32'd0, 2'b01);
      tick();
    end
    n_checks++;
    if (inst_valid !== 1'b1 || pc_IFR !== exp_pc()) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b pc=%h want v=1 pc=%h", inst_valid, pc_IFR, exp_pc());
    end
    idle();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || pc_IFR !== 64'd0 || Instruction !== BUBBLE || wait_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL areset_now: got v=%b pc=%h inst=%h wait=%0d want v=0 pc=0 inst=%h wait=0",
               inst_valid, pc_IFR, Instruction, wait_cycles, BUBBLE);
    end
    mq.delete();
    m_wait = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            {$urandom, $urandom}, int'($urandom_range(0, 1)), $urandom, $urandom,
            {$urandom_range(0, 2) != 0, 1'b1});
      n_checks++;
      if (ifp_hold !== exp_hold) begin
        n_fail++;
        $display("FAIL rand_hold[%0d]: got %b want %b", i, ifp_hold, exp_hold);
      end
      tick();
      n_checks++;
      if (inst_valid !== exp_valid() || pc_IFR !== exp_pc() || Instruction !== exp_inst()
          || wait_cycles !== m_wait) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b pc=%h inst=%h wait=%0d want v=%b pc=%h inst=%h wait=%0d",
                 i, inst_valid, pc_IFR, Instruction, wait_cycles,
                 exp_valid(), exp_pc(), exp_inst(), m_wait);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    pc_valid = 1'b0;
    pc_IFP   = '0;
    ch_sel   = '0;
    ch_dout  = '0;
    ch_ready = 2'b01;
    m_wait   = 32'd0;
    @(negedge clk);
    test_reset();
    test_rom_stream();
    test_dram_wait();
    test_fill();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ifr_queue.md
PIPELINE_IFR_QUEUE -- requirements
Module: pipeline_ifr_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 SHALL have parameter NCH, default 2, fetch source channels (channel 0 = ROM, channel 1 = DRAM/cache); >= 1.
REQ-005 SHALL have parameter BUBBLE_INST, default 32'h00000013, instruction driven when no valid entry.
REQ-006 SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-007 SHALL provide port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL provide port stall, input, 1, downstream (ID) not accepting this cycle.
REQ-009 SHALL provide port flush, input, 1, synchronous discard of all queued and incoming fetches.
REQ-010 SHALL provide port pc_IFP, input, XLEN, PC of the fetch presented by IFP.
REQ-011 SHALL provide port pc_valid, input, 1, IFP presents a fetch this cycle.
REQ-012 SHALL provide port ch_sel, input, max(1,$clog2(NCH)), source channel of the presented fetch.
REQ-013 SHALL provide port ch_dout, input, NCH*ILEN, per-channel read data; channel k occupies bits [k*ILEN +: ILEN].
REQ-014 SHALL provide port ch_ready, input, NCH, per-channel data-ready; ROM channel tied 1 at integration.
REQ-015 SHALL provide port pc_IFR, output, XLEN, PC of the head entry.
REQ-016 SHALL provide port Instruction, output, ILEN, instruction of the head entry.
REQ-017 SHALL provide port inst_valid, output, 1, head entry valid.
REQ-018 SHALL provide port ifp_hold, output, 1, combinational backpressure telling IFP to keep pc_IFP.
REQ-019 SHALL provide port wait_cycles, output, 32, saturating count of cycles a fetch waited on data.

Function
REQ-020 SHALL implement a circular FIFO with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy count in the range 0..DEPTH.
REQ-021 SHALL compute pop = inst_valid && !stall.
REQ-022 SHALL compute sel_ok = (ch_sel < NCH) && ch_ready[ch_sel]; an out-of-range ch_sel SHALL be treated as not ready.
REQ-023 SHALL compute push = pc_valid && sel_ok && (count < DEPTH || pop) && !flush.
REQ-024 SHALL drive ifp_hold = pc_valid && !push && !flush.
REQ-025 SHALL store {pc_IFP, selected ch_dout slice} at the write pointer on push.
REQ-026 SHALL set count_next = count + push - pop; simultaneous push and pop SHALL be legal when full, and count SHALL stay DEPTH.
REQ-027 SHALL drive pc_IFR and Instruction from the head storage register and inst_valid = (count != 0); outputs SHALL be registered-state-only with no combinational path from any input.
REQ-028 SHALL, when empty, drive pc_IFR = 0 and Instruction = BUBBLE_INST.
REQ-029 SHALL make a fetch pushed at edge N visible on the outputs after edge N (one-cycle latency when empty).
REQ-030 SHALL leave outputs and state unchanged when stall=1 with no push.
REQ-031 SHALL, on flush=1 at an edge, clear count and pointers to 0 and ignore push and pop that cycle; flush SHALL take priority over stall.
REQ-032 SHALL NOT insert a zero instruction while the DRAM channel is not ready; it SHALL hold the fetch via ifp_hold instead.
REQ-033 SHALL increment wait_cycles at each edge where pc_valid && !sel_ok && !flush, saturating at 32'hFFFFFFFF; flush SHALL NOT clear it.

Reset
REQ-034 SHALL, while reset=0, asynchronously force count=0, pointers=0, wait_cycles=0, inst_valid=0, pc_IFR=0, Instruction=BUBBLE_INST.
REQ-035 SHALL resume normal operation on the first rising clk edge after reset deasserts; storage contents need not be cleared.

Verification
REQ-036 SHALL cover ROM stream: ch_sel=0, pc_valid=1, PCs 0x1000,0x1004,0x1008, stall=0 -> outputs show the same PCs one cycle later, inst_valid=1, ifp_hold=0.
REQ-037 SHALL cover DRAM wait: ch_sel=1, ch_ready[1]=0 for 3 cycles, then 1 with ch_dout=0x00500093 -> ifp_hold=1 for 3 cycles, wait_cycles=3, then Instruction=0x00500093.
REQ-038 SHALL cover fill: stall=1 with 5 ROM fetches at DEPTH=4 -> 4 pushes, ifp_hold=1 on the 5th; on stall release, pop and push in the same cycle keep count=4, and entries drain in FIFO order.
REQ-039 SHALL cover flush while full plus incoming fetch: flush=1 -> next cycle inst_valid=0, Instruction=0x00000013, and the incoming fetch is dropped.
REQ-040 SHALL cover async reset mid-stream: reset=0 between edges -> outputs clear immediately without waiting for clk.
REQ-041 SHALL cover pointer wrap: 10 push/pop pairs at DEPTH=4 -> order preserved and no spurious valid.
